// File: rtl/rlc_filter_pkg.sv
// Shared formats, coefficient quantisation and rounding helpers for rlc_filter.
// Saturation is enabled by defining RLC_FILTER_SAT_EN; otherwise results wrap.
package rlc_filter_pkg;

  localparam int V_IN_WIDTH_DEF     = 18;
  localparam int V_IN_EXPONENT_DEF  = -16;
  localparam int V_OUT_WIDTH_DEF    = 18;
  localparam int V_OUT_EXPONENT_DEF = -13;
  localparam int I_WIDTH_DEF        = 32;
  localparam int I_EXPONENT_DEF     = -28;
  localparam int VC_WIDTH_DEF       = 32;
  localparam int VC_EXPONENT_DEF    = -24;
  localparam int COEF_FRAC          = 20;

  // Intermediate width: wide enough that no product or sum overflows before the final fit.
  localparam int WIDE_W = 96;
  typedef logic signed [WIDE_W-1:0] wide_t;

`ifdef RLC_FILTER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Quantise a real coefficient to COEF_FRAC fractional bits (cast rounds half away from zero).
  function automatic longint real_to_coef(input real v);
    return longint'(v * (2.0 ** COEF_FRAC));
  endfunction

  // shift = destination exponent - source exponent; positive shifts right with symmetric rounding.
  function automatic wide_t rescale_round(input wide_t x, input int shift);
    wide_t mag;
    if (shift <= 0) return x <<< (-shift);
    mag = x[WIDE_W-1] ? -x : x;
    mag = (mag + (wide_t'(1) <<< (shift - 1))) >>> shift;
    return x[WIDE_W-1] ? -mag : mag;
  endfunction

  function automatic wide_t sat_to(input wide_t x, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Fit a wide value into w bits: clamp when saturation is built in, else leave for truncation.
  function automatic wide_t fit(input wide_t x, input int w);
    return SAT_EN ? sat_to(x, w) : x;
  endfunction

endpackage

// File: rtl/rlc_fxp_mul_rescale.sv
// Signed multiply by a constant fixed-point coefficient, rescaled to OUT_EXP with
// round-half-away-from-zero; clamps to OUT_WIDTH when RLC_FILTER_SAT_EN is defined.
module rlc_fxp_mul_rescale
  import rlc_filter_pkg::*;
#(
  parameter int     IN_WIDTH  = 32,
  parameter int     IN_EXP    = -28,
  parameter longint COEF      = 0,
  parameter int     OUT_WIDTH = 32,
  parameter int     OUT_EXP   = -28
) (
  input  logic signed [IN_WIDTH-1:0]  a,
  output logic signed [OUT_WIDTH-1:0] y
);

  localparam int SHIFT = OUT_EXP - IN_EXP + COEF_FRAC;

  always_comb begin
    y = OUT_WIDTH'(fit(rescale_round(wide_t'(a) * wide_t'(COEF), SHIFT), OUT_WIDTH));
  end

endmodule

// File: rtl/rlc_filter.sv
// Discrete-time series-R/L, shunt-C low-pass plant; one semi-implicit Euler step per clk.
// Define RLC_FILTER_SAT_EN to saturate i, vc and v_out instead of wrapping.
module rlc_filter
  import rlc_filter_pkg::*;
#(
  parameter int  V_IN_WIDTH     = V_IN_WIDTH_DEF,
  parameter int  V_IN_EXPONENT  = V_IN_EXPONENT_DEF,
  parameter int  V_OUT_WIDTH    = V_OUT_WIDTH_DEF,
  parameter int  V_OUT_EXPONENT = V_OUT_EXPONENT_DEF,
  parameter int  I_WIDTH        = I_WIDTH_DEF,
  parameter int  I_EXPONENT     = I_EXPONENT_DEF,
  parameter int  VC_WIDTH       = VC_WIDTH_DEF,
  parameter int  VC_EXPONENT    = VC_EXPONENT_DEF,
  parameter real DT             = 1.0e-8,
  parameter real R_OHM          = 20.0,
  parameter real L_H            = 1.0e-6,
  parameter real C_F            = 1.0e-9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [V_IN_WIDTH-1:0]  v_in,
  output logic signed [V_OUT_WIDTH-1:0] v_out
);

  localparam longint KI = real_to_coef(DT / L_H);
  localparam longint KV = real_to_coef(DT / C_F);
  localparam longint KR = real_to_coef(R_OHM);

  // Voltage sums are formed on the finest of the input/state grids.
  localparam int GRID_EXP =
    (I_EXPONENT < VC_EXPONENT)
      ? ((I_EXPONENT < V_IN_EXPONENT) ? I_EXPONENT : V_IN_EXPONENT)
      : ((VC_EXPONENT < V_IN_EXPONENT) ? VC_EXPONENT : V_IN_EXPONENT);

  logic signed [I_WIDTH-1:0]     i_q, i_next;
  logic signed [VC_WIDTH-1:0]    vc_q, vc_next;
  logic signed [V_OUT_WIDTH-1:0] v_out_next;
  wide_t                         kr_i, ki_d, kv_i, diff;

  rlc_fxp_mul_rescale #(
    .IN_WIDTH (I_WIDTH),
    .IN_EXP   (I_EXPONENT),
    .COEF     (KR),
    .OUT_WIDTH(WIDE_W),
    .OUT_EXP  (GRID_EXP)
  ) u_kr (
    .a(i_q),
    .y(kr_i)
  );

  rlc_fxp_mul_rescale #(
    .IN_WIDTH (WIDE_W),
    .IN_EXP   (GRID_EXP),
    .COEF     (KI),
    .OUT_WIDTH(WIDE_W),
    .OUT_EXP  (I_EXPONENT)
  ) u_ki (
    .a(diff),
    .y(ki_d)
  );

  // Semi-implicit: the capacitor update uses the freshly computed current.
  rlc_fxp_mul_rescale #(
    .IN_WIDTH (I_WIDTH),
    .IN_EXP   (I_EXPONENT),
    .COEF     (KV),
    .OUT_WIDTH(WIDE_W),
    .OUT_EXP  (VC_EXPONENT)
  ) u_kv (
    .a(i_next),
    .y(kv_i)
  );

  always_comb begin
    diff = rescale_round(wide_t'(v_in), GRID_EXP - V_IN_EXPONENT)
         - kr_i
         - rescale_round(wide_t'(vc_q), GRID_EXP - VC_EXPONENT);
  end

  always_comb begin
    i_next = I_WIDTH'(fit(wide_t'(i_q) + ki_d, I_WIDTH));
  end

  always_comb begin
    vc_next    = VC_WIDTH'(fit(wide_t'(vc_q) + kv_i, VC_WIDTH));
    v_out_next = V_OUT_WIDTH'(fit(rescale_round(wide_t'(vc_next), V_OUT_EXPONENT - VC_EXPONENT),
                                  V_OUT_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q   <= '0;
      vc_q  <= '0;
      v_out <= '0;
    end else begin
      i_q   <= i_next;
      vc_q  <= vc_next;
      v_out <= v_out_next;
    end
  end

endmodule

// File: tb/tb_rlc_filter.sv
// Directed bench for rlc_filter: reset, step, square wave, negation, mid-run reset, overflow.
module tb_rlc_filter;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] v_in, v_out;
  logic signed [17:0] v_in_sat, v_out_sat;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  localparam longint ONE_IN   = 65536;   // 1.0 at 2^-16
  localparam longint ONE_OUT  = 8192;    // 1.0 at 2^-13
  localparam longint IN_1P99  = 130417;  // 1.99 at 2^-16
  localparam real    M_KI     = 1.0e-8 / 1.0e-6;
  localparam real    M_KV     = 1.0e-8 / 1.0e-9;
  localparam real    M_R      = 20.0;

  real    m_i, m_vc;
  longint resp [250];
  longint peak, maxv, minv;
  int     peak_n;

  rlc_filter dut (
    .clk  (clk),
    .rst  (rst),
    .v_in (v_in),
    .v_out(v_out)
  );

  rlc_filter #(.V_OUT_EXPONENT(-16)) dut_sat (
    .clk  (clk),
    .rst  (rst),
    .v_in (v_in_sat),
    .v_out(v_out_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input longint obs, input longint lo, input longint hi);
    vectors++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic void model_reset();
    m_i  = 0.0;
    m_vc = 0.0;
  endfunction

  function automatic void model_step(input real vin);
    m_i  = m_i + M_KI * (vin - M_R * m_i - m_vc);
    m_vc = m_vc + M_KV * m_i;
  endfunction

  function automatic longint model_code(input real scale);
    return longint'(m_vc * scale);
  endfunction

  task automatic do_reset();
    v_in     = '0;
    v_in_sat = '0;
    rst      = 1'b1;
    #2;
    rst      = 1'b0;
    model_reset();
  endtask

  initial begin
    // Reset held with a nonzero drive, then idle after release.
    rst      = 1'b1;
    v_in     = 18'(ONE_IN);
    v_in_sat = '0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check_eq("reset_hold", v_out, 0);
    end
    rst  = 1'b0;
    v_in = '0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      check_eq("idle_zero", v_out, 0);
    end

    // Positive unit step.
    do_reset();
    v_in   = 18'(ONE_IN);
    peak   = -1;
    peak_n = 0;
    for (int n = 0; n < 250; n++) begin
      tick();
      model_step(1.0);
      resp[n] = v_out;
      check_range("step_track", v_out, model_code(8192.0) - 2, model_code(8192.0) + 2);
      if (resp[n] > peak) begin
        peak   = resp[n];
        peak_n = n + 1;
      end
      if (n >= 199) check_range("step_settled", v_out, ONE_OUT - 8, ONE_OUT + 8);
    end
    check_range("step_peak_value", peak, 10650, 11468);
    check_range("step_peak_clk", peak_n, 9, 12);

    // Square wave +/-1.0, 100-clk period.
    do_reset();
    maxv = -(longint'(1) <<< 40);
    minv = longint'(1) <<< 40;
    for (int n = 0; n < 1000; n++) begin
      v_in = (((n / 50) % 2) == 0) ? 18'(ONE_IN) : 18'(-ONE_IN);
      tick();
      model_step((((n / 50) % 2) == 0) ? 1.0 : -1.0);
      check_range("square_track", v_out, model_code(8192.0) - 2, model_code(8192.0) + 2);
      if (n >= 500) begin
        if (v_out > maxv) maxv = v_out;
        if (v_out < minv) minv = v_out;
      end
      if (n >= 100 && (n % 50) == 49)
        check_eq("square_sign", (v_out > 0) ? 1 : -1, (v_in > 0) ? 1 : -1);
    end
    check_range("square_peak", maxv, 12288, 15565);
    check_range("square_symmetry", maxv + minv, -2, 2);

    // Negative step mirrors the positive step.
    do_reset();
    v_in = 18'(-ONE_IN);
    for (int n = 0; n < 250; n++) begin
      tick();
      check_range("neg_step", v_out, -resp[n] - 1, -resp[n] + 1);
    end

    // Short reset pulse between edges during a step response.
    do_reset();
    v_in = 18'(ONE_IN);
    for (int n = 0; n < 30; n++) tick();
    check_range("pre_pulse_nonzero", v_out, 1, 20000);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_pulse_during", v_out, 0);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_pulse_after", v_out, 0);
    for (int n = 0; n < 250; n++) begin
      tick();
      check_eq("rst_repeat", v_out, resp[n]);
    end

    // Overflow on the 2^-16 output instance with a 1.99 step.
    do_reset();
    v_in_sat = 18'(IN_1P99);
    maxv = -(longint'(1) <<< 40);
    minv = longint'(1) <<< 40;
    for (int n = 0; n < 40; n++) begin
      tick();
      model_step(1.99);
      if (n < 4)
        check_range("ovf_early_track", v_out_sat,
                    model_code(65536.0) - 8, model_code(65536.0) + 8);
      if (v_out_sat > maxv) maxv = v_out_sat;
      if (v_out_sat < minv) minv = v_out_sat;
    end
`ifdef RLC_FILTER_SAT_EN
    check_eq("sat_clamp_max", maxv, 131071);
    check_range("sat_no_wrap", minv, 0, 131071);
`else
    check_range("wrap_negative", minv, -131072, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
